// File: rtl/mmio_timer_pkg.sv
// Shared definitions for mmio_timer_led: register byte offsets, CTRL/STATUS bit positions
// and the timer state encoding.
package mmio_timer_pkg;

  localparam logic [4:0] OFF_LED    = 5'h00;
  localparam logic [4:0] OFF_CTRL   = 5'h04;
  localparam logic [4:0] OFF_LOAD   = 5'h08;
  localparam logic [4:0] OFF_COUNT  = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;
  localparam logic [4:0] OFF_PRESC  = 5'h14;

  localparam int CTRL_ENABLE      = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 3;

  localparam int STATUS_EXPIRED = 0;
  localparam int STATUS_RUNNING = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

endpackage

// File: rtl/mmio_timer_led_if.sv
// Processor data-memory bus as seen by a memory-mapped responder.
interface mmio_timer_led_if;

  logic [31:0] address;
  logic [31:0] write_value;
  logic        write_enable;
  logic [31:0] read_value;
  logic        hit;

  modport master (
    output address, write_value, write_enable,
    input  read_value, hit
  );

  modport slave (
    input  address, write_value, write_enable,
    output read_value, hit
  );

endinterface

// File: rtl/mmio_prescaler.sv
// Free-running prescale counter: counts 0..reload while enabled and ticks on the terminal value.
module mmio_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] reload,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt_q;

  // >= rather than == so a reload shrunk below the current count wraps at once instead of running to overflow.
  assign tick = en & (cnt_q >= reload);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mmio_timer_led.sv
// MMIO LED register plus prescaled down-counting timer with sticky expiry flag.
// Optional build macro MMIO_TIMER_IRQ_EN adds the irq output and a stored CTRL.irq_en bit.
module mmio_timer_led
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0400,
  parameter logic [31:0] ADDR_MASK      = 32'hFFFF_FFE0,
  parameter int          LED_WIDTH      = 18,
  parameter int          PRESCALE_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  mmio_timer_led_if.slave      bus,
  output logic [LED_WIDTH-1:0] LEDR,
  output logic                 timer_expired
`ifdef MMIO_TIMER_IRQ_EN
  ,
  output logic                 irq
`endif
);

  logic [4:0]  offset;
  logic        reg_we;
  logic        wr_led, wr_ctrl, wr_load, wr_count, wr_status, wr_presc;
  logic [31:0] wdata;

  timer_state_t              state_q;
  logic                      enable_q;
  logic                      auto_reload_q;
  logic                      irq_en_bit;
  logic                      expired_q;
  logic [31:0]               load_q;
  logic [31:0]               count_q;
  logic [LED_WIDTH-1:0]      led_q;
  logic [PRESCALE_WIDTH-1:0] presc_q;

  logic tick;
  logic start;
  logic expire_evt;
  logic [31:0] rdata;

  // Address decode: word offset inside the window, byte lane bits ignored.
  assign bus.hit   = (bus.address & ADDR_MASK) == BASE_ADDR;
  assign offset    = {bus.address[4:2], 2'b00};
  assign reg_we    = bus.write_enable & bus.hit;
  assign wdata     = bus.write_value;
  assign wr_led    = reg_we && (offset == OFF_LED);
  assign wr_ctrl   = reg_we && (offset == OFF_CTRL);
  assign wr_load   = reg_we && (offset == OFF_LOAD);
  assign wr_count  = reg_we && (offset == OFF_COUNT);
  assign wr_status = reg_we && (offset == OFF_STATUS);
  assign wr_presc  = reg_we && (offset == OFF_PRESC);

  assign start = wr_ctrl & wdata[CTRL_ENABLE] & (state_q == IDLE);
  // A direct COUNT store overrides the whole tick, including expiry.
  assign expire_evt = tick & ~wr_count & (count_q == '0);

  mmio_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .en    (state_q == RUN),
    .clear (start),
    .reload(presc_q),
    .tick  (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q   <= '0;
      load_q  <= '0;
      presc_q <= '0;
    end else begin
      if (wr_led)   led_q   <= wdata[LED_WIDTH-1:0];
      if (wr_load)  load_q  <= wdata;
      if (wr_presc) presc_q <= wdata[PRESCALE_WIDTH-1:0];
    end
  end

`ifdef MMIO_TIMER_IRQ_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_en_bit <= 1'b0;
    end else if (wr_ctrl) begin
      irq_en_bit <= wdata[CTRL_IRQ_EN];
    end
  end

  assign irq = expired_q & irq_en_bit;
`else
  assign irq_en_bit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      enable_q      <= 1'b0;
      auto_reload_q <= 1'b0;
      count_q       <= '0;
      expired_q     <= 1'b0;
    end else begin
      if (wr_count) begin
        count_q <= wdata;
      end else if (tick) begin
        if (count_q != '0)     count_q <= count_q - 32'd1;
        else if (auto_reload_q) count_q <= load_q;
      end

      // Set beats a simultaneous write-1-to-clear.
      if (expire_evt)                             expired_q <= 1'b1;
      else if (wr_status && wdata[STATUS_EXPIRED]) expired_q <= 1'b0;

      if (wr_ctrl) begin
        enable_q      <= wdata[CTRL_ENABLE];
        auto_reload_q <= wdata[CTRL_AUTO_RELOAD];
      end else if (expire_evt && !auto_reload_q) begin
        enable_q <= 1'b0;
      end

      case (state_q)
        IDLE: if (start) state_q <= RUN;
        RUN: begin
          if (wr_ctrl) begin
            if (!wdata[CTRL_ENABLE]) state_q <= IDLE;
          end else if (expire_evt && !auto_reload_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.hit) begin
      case (offset)
        OFF_LED:   rdata = 32'(led_q);
        OFF_CTRL: begin
          rdata[CTRL_ENABLE]      = enable_q;
          rdata[CTRL_AUTO_RELOAD] = auto_reload_q;
          rdata[CTRL_IRQ_EN]      = irq_en_bit;
        end
        OFF_LOAD:  rdata = load_q;
        OFF_COUNT: rdata = count_q;
        OFF_STATUS: begin
          rdata[STATUS_EXPIRED] = expired_q;
          rdata[STATUS_RUNNING] = (state_q == RUN);
        end
        OFF_PRESC: rdata = 32'(presc_q);
        default:   rdata = '0;
      endcase
    end
  end

  assign bus.read_value = rdata;
  assign LEDR           = led_q;
  assign timer_expired  = expired_q;

endmodule

// File: tb/tb_mmio_timer_led.sv
// Directed and randomized bench for mmio_timer_led against a register-level behavioural model.
module tb_mmio_timer_led;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam logic [31:0] MASK = 32'hFFFF_FFE0;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [17:0] LEDR;
  logic        timer_expired;
`ifdef MMIO_TIMER_IRQ_EN
  logic        irq;
`endif

  mmio_timer_led_if bus();

  mmio_timer_led #(
    .BASE_ADDR(BASE), .ADDR_MASK(MASK), .LED_WIDTH(18), .PRESCALE_WIDTH(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .LEDR(LEDR),
    .timer_expired(timer_expired)
`ifdef MMIO_TIMER_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: register contents plus clocks elapsed in the current prescale period.
  logic [17:0] m_led;
  logic        m_en, m_ar, m_irqen, m_expired;
  logic [31:0] m_load, m_count;
  logic [15:0] m_presc;
  int          m_phase;

  task automatic model_reset();
    m_led = '0; m_en = 1'b0; m_ar = 1'b0; m_irqen = 1'b0; m_expired = 1'b0;
    m_load = '0; m_count = '0; m_presc = '0; m_phase = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if ((a & MASK) != BASE) return 32'h0;
    case (a[4:2])
      3'd0: return {14'h0, m_led};
      3'd1: return {28'h0, m_irqen, 1'b0, m_ar, m_en};
      3'd2: return m_load;
      3'd3: return m_count;
      3'd4: return {30'h0, m_en, m_expired};
      3'd5: return {16'h0, m_presc};
      default: return 32'h0;
    endcase
  endfunction

  // One rising edge worth of behaviour, from the pre-edge model state and bus inputs.
  task automatic model_clock(input logic w_in, input logic [31:0] a, input logic [31:0] d);
    logic w, tick, cwr, expire;
    int   off;
    w      = w_in && ((a & MASK) == BASE);
    off    = int'(a[4:2]);
    tick   = m_en && (m_phase == int'(m_presc));
    cwr    = w && off == 3;
    expire = tick && !cwr && (m_count == 0);

    if (w && off == 1 && d[0] && !m_en) m_phase = 0;
    else if (m_en)                      m_phase = tick ? 0 : m_phase + 1;

    if (cwr) m_count = d;
    else if (tick) begin
      if (m_count != 0) m_count = m_count - 32'd1;
      else if (m_ar)    m_count = m_load;
    end

    if (expire)                       m_expired = 1'b1;
    else if (w && off == 4 && d[0])   m_expired = 1'b0;

    if (w && off == 1) begin
      m_en = d[0];
      m_ar = d[1];
`ifdef MMIO_TIMER_IRQ_EN
      m_irqen = d[3];
`endif
    end else if (expire && !m_ar) begin
      m_en = 1'b0;
    end

    if (w && off == 0) m_led   = d[17:0];
    if (w && off == 2) m_load  = d;
    if (w && off == 5) m_presc = d[15:0];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.address      = a;
    bus.write_value  = d;
    bus.write_enable = w;
    @(posedge clock);
    model_clock(w, a, d);
    #1;
    bus.write_enable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, a, d);
  endtask

  task automatic idle();
    cyc(1'b0, BASE + 32'h18, 32'h0);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.address      = a;
    bus.write_enable = 1'b0;
    #1;
    check(tag, bus.read_value, exp);
  endtask

  task automatic rd_model(input string tag, input logic [31:0] a);
    rd_check(tag, a, model_read(a));
  endtask

  initial begin
    bus.address      = '0;
    bus.write_value  = '0;
    bus.write_enable = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_ledr", 32'(LEDR), 32'h0);
    check("rst_expired", 32'(timer_expired), 32'h0);
    rd_check("rst_ctrl", BASE + 32'h04, 32'h0);
    rd_check("rst_count", BASE + 32'h0C, 32'h0);
    rd_check("rst_status", BASE + 32'h10, 32'h0);
    reset = 1'b1;

    // LED register and window decode
    wr(BASE, 32'h0002_AAAA);
    check("led_ledr", 32'(LEDR), 32'h0002_AAAA);
    rd_check("led_read", BASE, 32'h0002_AAAA);
    rd_check("miss_read", 32'h0000_03FC, 32'h0);
    check("miss_hit", 32'(bus.hit), 32'h0);
    rd_check("unused_read", BASE + 32'h18, 32'h0);
    check("unused_hit", 32'(bus.hit), 32'h1);

    // One-shot, PRESC=0, COUNT=3
    wr(BASE + 32'h14, 32'd0);
    wr(BASE + 32'h0C, 32'd3);
    wr(BASE + 32'h04, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      idle();
      check($sformatf("oneshot_expired_c%0d", i), 32'(timer_expired), 32'(i == 4));
    end
    rd_check("oneshot_ctrl", BASE + 32'h04, 32'h0);
    rd_check("oneshot_count", BASE + 32'h0C, 32'h0);
    rd_check("oneshot_status", BASE + 32'h10, 32'h1);

    // Auto-reload, PRESC=2, LOAD=1: expiry every 6 clocks, set beats clear
    wr(BASE + 32'h10, 32'h1);
    check("ar_cleared", 32'(timer_expired), 32'h0);
    wr(BASE + 32'h14, 32'd2);
    wr(BASE + 32'h08, 32'd1);
    wr(BASE + 32'h0C, 32'd1);
    wr(BASE + 32'h04, 32'h3);
    repeat (5) idle();
    check("ar_expired_c5", 32'(timer_expired), 32'h0);
    idle();
    check("ar_expired_c6", 32'(timer_expired), 32'h1);
    wr(BASE + 32'h10, 32'h1);
    check("ar_clear_c7", 32'(timer_expired), 32'h0);
    repeat (4) idle();
    check("ar_expired_c11", 32'(timer_expired), 32'h0);
    wr(BASE + 32'h10, 32'h1);
    check("ar_setwins_c12", 32'(timer_expired), 32'h1);
    rd_check("ar_status", BASE + 32'h10, 32'h3);
    rd_model("ar_count_model", BASE + 32'h0C);
    wr(BASE + 32'h04, 32'h0);
    wr(BASE + 32'h10, 32'h1);

    // COUNT store on a tick wins; stopped timer holds COUNT
    wr(BASE + 32'h14, 32'd0);
    wr(BASE + 32'h0C, 32'd10);
    wr(BASE + 32'h04, 32'h1);
    idle();
    rd_check("cw_count_9", BASE + 32'h0C, 32'd9);
    wr(BASE + 32'h0C, 32'd7);
    rd_check("cw_count_7", BASE + 32'h0C, 32'd7);
    wr(BASE + 32'h04, 32'h0);
    for (int i = 0; i < 20; i++) begin
      idle();
      rd_check($sformatf("hold_count_c%0d", i), BASE + 32'h0C, 32'd6);
    end
    rd_check("hold_status", BASE + 32'h10, 32'h0);

`ifdef MMIO_TIMER_IRQ_EN
    wr(BASE + 32'h0C, 32'd0);
    wr(BASE + 32'h04, 32'h9);
    idle();
    check("irq_set", 32'(irq), 32'h1);
    rd_check("irq_ctrl", BASE + 32'h04, 32'h8);
    wr(BASE + 32'h10, 32'h1);
    check("irq_clear", 32'(irq), 32'h0);
    wr(BASE + 32'h04, 32'h0);
`else
    wr(BASE + 32'h04, 32'h8);
    rd_check("noirq_ctrl_bit3", BASE + 32'h04, 32'h0);
    wr(BASE + 32'h04, 32'h0);
`endif

    // Asynchronous reset in the middle of a count
    wr(BASE, 32'h0003_FFFF);
    wr(BASE + 32'h14, 32'd3);
    wr(BASE + 32'h0C, 32'd5);
    wr(BASE + 32'h04, 32'h1);
    idle();
    idle();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("arst_ledr", 32'(LEDR), 32'h0);
    check("arst_expired", 32'(timer_expired), 32'h0);
    rd_check("arst_count", BASE + 32'h0C, 32'h0);
    rd_check("arst_ctrl", BASE + 32'h04, 32'h0);
    rd_check("arst_status", BASE + 32'h10, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      idle();
      check($sformatf("arst_nopulse_c%0d", i), 32'(timer_expired), 32'h0);
    end

    // Randomized traffic against the model
    wr(BASE + 32'h14, 32'($urandom_range(0, 3)));
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, d;
      logic        w;
      int unsigned r;
      r = $urandom_range(0, 9);
      w = 1'b1;
      a = BASE;
      d = 32'h0;
      case (r)
        0, 1, 2, 3, 4: begin w = 1'b0; a = BASE + 32'($urandom_range(0, 7) * 4); end
        5: begin a = BASE + 32'h0C; d = 32'($urandom_range(0, 6)); end
        6: begin a = BASE + 32'h10; d = 32'($urandom_range(0, 1)); end
        7: begin
          a = BASE + 32'h04;
          d = 32'($urandom_range(0, 15));
          if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
        end
        8: begin a = BASE + 32'h08; d = 32'($urandom_range(0, 5)); end
        default: begin a = ($urandom_range(0, 1) != 0) ? BASE : BASE + 32'h20; d = $urandom; end
      endcase
      cyc(w, a, d);
      check($sformatf("rnd_ledr_%0d", i), 32'(LEDR), 32'(m_led));
      check($sformatf("rnd_expired_%0d", i), 32'(timer_expired), 32'(m_expired));
`ifdef MMIO_TIMER_IRQ_EN
      check($sformatf("rnd_irq_%0d", i), 32'(irq), 32'(m_expired & m_irqen));
`endif
      rd_model($sformatf("rnd_read_%0d", i), BASE + 32'($urandom_range(0, 7) * 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
